// File: rtl/fetch_unit.sv
// fetch_unit: fetches whole cache lines over a wide bus into an instruction FIFO.
// Instructions below fetch_pc are dropped; redirects flush and drain cleanly.
module fetch_unit #(
    parameter int BUS_DATA_WIDTH = 64,
    parameter int BUS_TAG_WIDTH = 13,
    parameter int LINE_BEATS = 8,
    parameter int FIFO_DEPTH = 32,
    parameter logic [BUS_TAG_WIDTH-1:0] READ_TAG = 13'h1100
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [63:0]               entry,
    input  logic                      redirect_valid,
    input  logic [63:0]               redirect_pc,
    output logic                      bus_reqcyc,
    output logic [BUS_DATA_WIDTH-1:0] bus_req,
    output logic [BUS_TAG_WIDTH-1:0]  bus_reqtag,
    input  logic                      bus_reqack,
    input  logic                      bus_respcyc,
    input  logic [BUS_DATA_WIDTH-1:0] bus_resp,
    input  logic [BUS_TAG_WIDTH-1:0]  bus_resptag,
    output logic                      bus_respack,
    output logic                      inst_valid,
    output logic [31:0]               inst,
    output logic [63:0]               inst_pc,
    input  logic                      inst_ready
);

    localparam int IPB = BUS_DATA_WIDTH / 32;
    localparam int IPL = IPB * LINE_BEATS;
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;
    localparam int BW = (LINE_BEATS > 1) ? $clog2(LINE_BEATS) : 1;
    localparam logic [63:0] LB = 64'(LINE_BEATS * BUS_DATA_WIDTH / 8);
    localparam logic [CW-1:0] ROOM = CW'(FIFO_DEPTH - IPL);
    localparam logic [BW-1:0] LAST = BW'(LINE_BEATS - 1);

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        RESP,
        DRAIN
    } state_t;

    state_t state;
    state_t next_state;

    logic [63:0] fetch_pc;
    logic [63:0] line_base;
    logic [BW-1:0] beat;
    logic started;
    logic last_beat;
    logic can_fetch;
    logic pop;
    logic push_en;

    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [CW-1:0] count;
    logic [31:0] mem_inst [FIFO_DEPTH];
    logic [63:0] mem_pc [FIFO_DEPTH];

    logic [IPB-1:0] push;
    logic [PW-1:0] slot [IPB];
    logic [63:0] slot_pc [IPB];
    logic [CW-1:0] push_n;

    logic unused_tag;
    assign unused_tag = ^bus_resptag;

    assign line_base = fetch_pc & ~(LB - 64'd1);
    assign last_beat = bus_respcyc && (beat == LAST);
    // started delays the first request by one edge after reset release
    assign can_fetch = started && (count <= ROOM);
    assign inst_valid = (count != '0);
    assign pop = inst_ready && inst_valid;
    assign inst = mem_inst[rd_ptr];
    assign inst_pc = mem_pc[rd_ptr];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        unique case (state)
            IDLE: begin
                if (!redirect_valid && can_fetch) next_state = REQ;
            end
            REQ: begin
                if (redirect_valid) next_state = bus_reqack ? DRAIN : IDLE;
                else if (bus_reqack) next_state = RESP;
            end
            RESP: begin
                if (last_beat) next_state = IDLE;
                else if (redirect_valid) next_state = DRAIN;
            end
            DRAIN: begin
                if (last_beat) next_state = IDLE;
            end
            default: next_state = IDLE;
        endcase
    end

    always_comb begin
        bus_reqcyc = 1'b0;
        bus_req = '0;
        bus_reqtag = '0;
        bus_respack = 1'b0;
        push_en = 1'b0;
        unique case (state)
            REQ: begin
                bus_reqcyc = 1'b1;
                bus_req = BUS_DATA_WIDTH'(line_base);
                bus_reqtag = READ_TAG;
            end
            RESP: begin
                bus_respack = bus_respcyc;
                push_en = bus_respcyc && !redirect_valid;
            end
            DRAIN: begin
                bus_respack = bus_respcyc;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            fetch_pc <= entry;
            beat <= '0;
            started <= 1'b0;
        end else begin
            started <= 1'b1;
            if (redirect_valid) begin
                fetch_pc <= redirect_pc;
            end else if (state == RESP && last_beat) begin
                fetch_pc <= line_base + LB;
            end
            if (state == REQ && bus_reqack) begin
                beat <= '0;
            end else if (bus_respack) begin
                beat <= beat + BW'(1);
            end
        end
    end

    // Qualifying slots of a beat are packed densely from wr_ptr upward
    always_comb begin
        push_n = '0;
        for (int k = 0; k < IPB; k++) begin
            slot_pc[k] = line_base + 64'((int'(beat) * IPB + k) * 4);
            slot[k] = wr_ptr + PW'(push_n);
            push[k] = push_en && (slot_pc[k] >= fetch_pc);
            push_n = push_n + CW'(push[k]);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count <= '0;
        end else if (redirect_valid) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count <= '0;
        end else begin
            wr_ptr <= wr_ptr + PW'(push_n);
            rd_ptr <= rd_ptr + PW'(pop);
            count <= count + push_n - CW'(pop);
        end
    end

    always_ff @(posedge clk) begin
        for (int k = 0; k < IPB; k++) begin
            if (push[k]) begin
                mem_inst[slot[k]] <= bus_resp[32*k +: 32];
                mem_pc[slot[k]] <= slot_pc[k];
            end
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: randomized bus slave and consumer against a sequential-PC stream model.
// Directed phases cover line fill, partial line, full FIFO, redirects and async reset.
module tb_fetch_unit;

    localparam int BDW = 64;
    localparam int BTW = 13;
    localparam int LBEATS = 8;
    localparam int DEPTH = 32;
    localparam int IPB = BDW / 32;
    localparam logic [63:0] LB = 64'(LBEATS * BDW / 8);
    localparam logic [BTW-1:0] READ_TAG = 13'h1100;

    logic clk;
    logic reset;
    logic [63:0] entry;
    logic redirect_valid;
    logic [63:0] redirect_pc;
    logic bus_reqcyc;
    logic [BDW-1:0] bus_req;
    logic [BTW-1:0] bus_reqtag;
    logic bus_reqack;
    logic bus_respcyc;
    logic [BDW-1:0] bus_resp;
    logic [BTW-1:0] bus_resptag;
    logic bus_respack;
    logic inst_valid;
    logic [31:0] inst;
    logic [63:0] inst_pc;
    logic inst_ready;

    fetch_unit #(
        .BUS_DATA_WIDTH(BDW),
        .BUS_TAG_WIDTH(BTW),
        .LINE_BEATS(LBEATS),
        .FIFO_DEPTH(DEPTH),
        .READ_TAG(READ_TAG)
    ) dut (
        .clk(clk),
        .reset(reset),
        .entry(entry),
        .redirect_valid(redirect_valid),
        .redirect_pc(redirect_pc),
        .bus_reqcyc(bus_reqcyc),
        .bus_req(bus_req),
        .bus_reqtag(bus_reqtag),
        .bus_reqack(bus_reqack),
        .bus_respcyc(bus_respcyc),
        .bus_resp(bus_resp),
        .bus_resptag(bus_resptag),
        .bus_respack(bus_respack),
        .inst_valid(inst_valid),
        .inst(inst),
        .inst_pc(inst_pc),
        .inst_ready(inst_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    int ready_pct, redir_permil, ack_delay, beat_pct;
    int acks_left, pops_left, n_pops, beats_sent;
    int sl_phase, sl_wait, sl_beat;
    logic [63:0] sl_base;
    logic [63:0] exp_pc, want_pc, first_pc, force_tgt;
    logic force_redir, redir_prev;
    logic [63:0] req_log [$];

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] mem_word(input logic [63:0] a);
        return (a[31:0] * 32'h9E37_79B1) ^ a[63:32] ^ 32'h1357_9BDF;
    endfunction

    function automatic logic [BDW-1:0] beat_data(input logic [63:0] base,
                                                 input int b);
        logic [BDW-1:0] d;
        for (int k = 0; k < IPB; k++)
            d[32*k +: 32] = mem_word(base + 64'((b * IPB + k) * 4));
        return d;
    endfunction

    function automatic logic [63:0] line_of(input logic [63:0] a);
        return a & ~(LB - 64'd1);
    endfunction

    function automatic logic [63:0] get_req(input int i);
        return (i < req_log.size()) ? req_log[i] : 64'hFFFF_FFFF_FFFF_FFFF;
    endfunction

    // Occasionally aim near the top of the address space to exercise wrap
    function automatic logic [63:0] rand_target();
        logic [63:0] t;
        if ($urandom_range(7) == 0)
            t = 64'hFFFF_FFFF_FFFF_FF80 + 64'($urandom_range(31)) * 64'd4;
        else
            t = {32'h0, $urandom} & ~64'h3;
        return t;
    endfunction

    task automatic model_reset(input logic [63:0] e);
        exp_pc = e;
        want_pc = e;
        sl_phase = 0;
        req_log.delete();
        n_pops = 0;
        beats_sent = 0;
        redir_prev = 1'b0;
        pops_left = 0;
        force_redir = 1'b0;
        first_pc = '1;
    endtask

    task automatic do_reset(input logic [63:0] e);
        reset = 1'b1;
        entry = e;
        bus_reqack = 1'b0;
        bus_respcyc = 1'b0;
        bus_resp = '0;
        redirect_valid = 1'b0;
        redirect_pc = '0;
        inst_ready = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_reqcyc", bus_reqcyc, 0);
        chk("rst_respack", bus_respack, 0);
        chk("rst_valid", inst_valid, 0);
        chk("rst_req", bus_req, 0);
        chk("rst_tag", bus_reqtag, 0);
        reset = 1'b0;
        model_reset(e);
        @(negedge clk);
        chk("first_req_early", bus_reqcyc, 0);
    endtask

    // One cycle: sample at negedge, drive inputs for the next posedge
    task automatic step();
        logic do_redir;
        logic [63:0] tgt;
        if (redir_prev) chk("flush_valid", inst_valid, 0);
        if (bus_reqcyc) begin
            chk("req_addr", bus_req, line_of(want_pc));
            chk("req_tag", bus_reqtag, READ_TAG);
        end
        bus_reqack = 1'b0;
        bus_respcyc = 1'b0;
        bus_resp = '0;
        if (sl_phase == 0 && bus_reqcyc && acks_left > 0) begin
            sl_phase = 1;
            sl_wait = (ack_delay >= 0) ? ack_delay : int'($urandom_range(3));
        end
        if (sl_phase == 1) begin
            if (!bus_reqcyc) begin
                sl_phase = 0;
            end else if (sl_wait == 0) begin
                bus_reqack = 1'b1;
                sl_base = bus_req;
                req_log.push_back(bus_req);
                acks_left--;
                sl_beat = 0;
                sl_phase = 2;
                want_pc = line_of(want_pc) + LB;
            end else begin
                sl_wait--;
            end
        end else if (sl_phase == 2) begin
            if (int'($urandom_range(99)) < beat_pct) begin
                bus_respcyc = 1'b1;
                bus_resp = beat_data(sl_base, sl_beat);
                sl_beat++;
                beats_sent++;
                if (sl_beat == LBEATS) sl_phase = 0;
            end
        end
        inst_ready = (pops_left > 0) || (int'($urandom_range(99)) < ready_pct);
        if (inst_ready && inst_valid) begin
            if (n_pops == 0) first_pc = inst_pc;
            chk("pop_pc", inst_pc, exp_pc);
            chk("pop_inst", inst, mem_word(exp_pc));
            exp_pc += 64'd4;
            n_pops++;
            if (pops_left > 0) pops_left--;
        end
        do_redir = force_redir || (int'($urandom_range(999)) < redir_permil);
        redirect_valid = do_redir;
        redirect_pc = '0;
        if (do_redir) begin
            tgt = force_redir ? force_tgt : rand_target();
            redirect_pc = tgt;
            exp_pc = tgt;
            want_pc = tgt;
        end
        force_redir = 1'b0;
        redir_prev = do_redir;
        #1;
        chk("respack", bus_respack, bus_respcyc);
        @(negedge clk);
    endtask

    initial begin
        #2ms;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1);
    end

    initial begin
        int guard;
        bus_resptag = '0;

        // Full line from 0x1000, consumer stalled until FIFO is full
        ready_pct = 0; redir_permil = 0; ack_delay = 3;
        beat_pct = 100; acks_left = 100;
        do_reset(64'h1000);
        repeat (100) step();
        chk("two_lines", req_log.size(), 2);
        chk("a_req0", get_req(0), 64'h1000);
        chk("a_req1", get_req(1), 64'h1040);
        chk("full_idle", bus_reqcyc, 0);
        pops_left = 1;
        repeat (20) step();
        chk("one_pop", n_pops, 1);
        chk("no_refetch", req_log.size(), 2);
        pops_left = 15;
        repeat (40) step();
        chk("sixteen_pops", n_pops, 16);
        chk("a_req2", get_req(2), 64'h1080);

        // Entry mid-line: only the tail of the line is delivered
        acks_left = 1; ack_delay = 1;
        do_reset(64'h1018);
        repeat (40) step();
        chk("b_req0", get_req(0), 64'h1000);
        pops_left = 100;
        repeat (30) step();
        chk("b_pops", n_pops, 10);
        chk("b_first_pc", first_pc, 64'h1018);
        pops_left = 0;

        // Redirect after beat 3: rest of line drained, refetch at new line
        acks_left = 10; ack_delay = 0;
        do_reset(64'h1000);
        guard = 0;
        while (guard < 100 && beats_sent < 4) begin step(); guard++; end
        chk("c_beats", beats_sent, 4);
        force_redir = 1'b1; force_tgt = 64'h2004;
        step();
        guard = 0;
        while (guard < 100 && req_log.size() < 2) begin step(); guard++; end
        chk("c_drained", beats_sent, 8);
        chk("c_req1", get_req(1), 64'h2000);
        pops_left = 4;
        repeat (30) step();
        chk("c_first_pc", first_pc, 64'h2004);

        // Redirect while the request is stalled
        acks_left = 0; ack_delay = 0;
        do_reset(64'h1000);
        guard = 0;
        while (guard < 20 && !bus_reqcyc) begin step(); guard++; end
        chk("d_req_seen", bus_reqcyc, 1);
        repeat (3) step();
        chk("d_held", bus_reqcyc, 1);
        force_redir = 1'b1; force_tgt = 64'h3000;
        step();
        chk("d_drop", bus_reqcyc, 0);
        acks_left = 5;
        guard = 0;
        while (guard < 20 && req_log.size() < 1) begin step(); guard++; end
        chk("d_req0", get_req(0), 64'h3000);

        // Asynchronous reset in the middle of a response
        acks_left = 10;
        do_reset(64'h1000);
        guard = 0;
        while (guard < 100 && beats_sent < 3) begin step(); guard++; end
        chk("e_beats", beats_sent, 3);
        reset = 1'b1;
        bus_respcyc = 1'b1; bus_reqack = 1'b0;
        redirect_valid = 1'b0; inst_ready = 1'b0;
        #1;
        chk("e_reqcyc", bus_reqcyc, 0);
        chk("e_respack", bus_respack, 0);
        chk("e_valid", inst_valid, 0);
        chk("e_req", bus_req, 0);
        chk("e_tag", bus_reqtag, 0);
        @(negedge clk);
        reset = 1'b0;
        model_reset(64'h1000);
        #1;
        chk("e_late_ack", bus_respack, 0);
        @(negedge clk);
        chk("e_late_ack2", bus_respack, 0);
        chk("e_first_early", bus_reqcyc, 0);
        bus_respcyc = 1'b0;
        guard = 0;
        while (guard < 20 && req_log.size() < 1) begin step(); guard++; end
        chk("e_req0", get_req(0), 64'h1000);

        // Random traffic, redirects and back-pressure
        acks_left = 1 << 30; ack_delay = -1; beat_pct = 70;
        ready_pct = 60; redir_permil = 15;
        do_reset({32'h0, $urandom} & ~64'h3);
        repeat (4000) step();
        chk("f_progress", n_pops > 100, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
